// File: rtl/stream_rr_arbiter_if.sv
// ============================================================================
// Module      : stream_rr_arbiter_if
// Description : Valid/ready bundle between NUM_REQ producers, the arbiter and
//               the shared sink.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface stream_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int SIZE    = 32
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      s_valid;
  logic [NUM_REQ-1:0]      s_ready;
  logic [NUM_REQ*SIZE-1:0] s_data;
  logic                    m_valid;
  logic                    m_ready;
  logic [SIZE-1:0]         m_data;
  logic [IDW-1:0]          m_id;
  logic                    busy;

  // Arbiter side
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_id, busy
  );

  // Producer/sink side
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_id, busy
  );
endinterface

`default_nettype wire

// File: rtl/stream_rr_arbiter.sv
// ============================================================================
// Module      : stream_rr_arbiter
// Description : Round-robin arbiter locking one of NUM_REQ streams onto a
//               shared sink for up to MAX_BURST beats per grant.
//               Define STREAM_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module stream_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int SIZE      = 32,
  parameter int MAX_BURST = 4
) (
  input  wire logic              clk,
  input  wire logic              reset,
  stream_rr_arbiter_if.slave     bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [IDW:0]   NUM_REQ_W = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0] LAST_IDX  = IDW'(NUM_REQ - 1);
  localparam logic [7:0]     LAST_BEAT = 8'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOCK = 2'b01
  } state_t;

  state_t         state_q;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [7:0]     beat_cnt_q, beat_cnt_d;

  logic [SIZE-1:0] data_arr [NUM_REQ];
  logic [IDW:0]    cand;
  logic            found;
  logic            hs;
  logic            release_grant;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = bus.s_data[g*SIZE +: SIZE];
  end

  // Circular search starting at ptr_q; ptr_q never leaves 0 in fixed-priority mode
  always_comb begin
    grant_d = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!found && bus.s_valid[cand[IDW-1:0]]) begin
        found   = 1'b1;
        grant_d = cand[IDW-1:0];
      end
    end
  end

`ifdef STREAM_ARB_FIXED_PRIO_EN
  assign ptr_d = '0;
`else
  assign ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
`endif

  assign beat_cnt_d    = beat_cnt_q + 8'd1;
  assign hs            = bus.m_valid & bus.m_ready;
  assign release_grant = (hs && (beat_cnt_q == LAST_BEAT)) || !bus.s_valid[grant_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|bus.s_valid) begin
            grant_q    <= grant_d;
            beat_cnt_q <= '0;
            state_q    <= S_LOCK;
          end
        end
        S_LOCK: begin
          if (hs) begin
            beat_cnt_q <= beat_cnt_d;
          end
          if (release_grant) begin
            ptr_q   <= ptr_d;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Datapath follows the locked grant directly so a beat passes with no added latency
  always_comb begin
    bus.s_ready = '0;
    bus.m_valid = 1'b0;
    bus.m_data  = '0;
    bus.m_id    = '0;
    bus.busy    = 1'b0;
    if (state_q == S_LOCK) begin
      bus.m_valid          = bus.s_valid[grant_q];
      bus.m_data           = data_arr[grant_q];
      bus.m_id             = grant_q;
      bus.s_ready[grant_q] = bus.m_ready;
      bus.busy             = 1'b1;
    end
  end

endmodule

`default_nettype wire
